// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer for a WIDTH-bit Johnson ring counter.
// Accepts CLEAR / SET_RATE / RUN_N / RUN_TO commands and issues one-cycle
// step and clear strobes with a direction. It also tracks the ring phase and
// provides the ring pattern expected for that phase.
module johnson_step_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             abort,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_arg,
   output logic             cmd_ready,
   output logic             jc_step,
   output logic             jc_dir,
   output logic             jc_clr,
   output logic [PW-1:0]    phase,
   output logic [WIDTH-1:0] pattern,
   output logic             busy,
   output logic             done
);

   // Controller states
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StClr  = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // Command opcodes
   localparam logic [1:0] OpClear   = 2'b00;
   localparam logic [1:0] OpSetRate = 2'b01;
   localparam logic [1:0] OpRunN    = 2'b10;
   localparam logic [1:0] OpRunTo   = 2'b11;

   // The ring has 2*WIDTH phases, numbered 0 .. 2*WIDTH-1
   localparam int unsigned   NPH     = 2 * WIDTH;
   localparam logic [PW-1:0] PH_LAST = PW'(NPH - 1);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [7:0]    rate_q, rate_d;
   logic [7:0]    presc_q, presc_d;
   logic [7:0]    rem_q, rem_d;
   logic          dir_q, dir_d;

   // RUN_TO helpers: target phase and forward distance from the current phase
   int unsigned   to_tgt;
   int unsigned   to_dist;
   logic [PW-1:0] phase_fwd;
   logic [PW-1:0] phase_rev;

   // Target and modular forward distance for RUN_TO, plus the neighbouring phases
   always_comb begin
      to_tgt    = 32'(cmd_arg[PW-1:0]) % NPH;
      to_dist   = (to_tgt + NPH - 32'(phase_q)) % NPH;
      phase_fwd = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      phase_rev = (phase_q == '0) ? PH_LAST : phase_q - PW'(1);
   end

   // Next-state, command decode and strobe generation; ena low freezes everything
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      rate_d    = rate_q;
      presc_d   = presc_q;
      rem_d     = rem_q;
      dir_d     = dir_q;
      jc_step   = 1'b0;
      jc_clr    = 1'b0;
      done      = 1'b0;
      cmd_ready = ena && (state_q == StIdle);

      if (ena) begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  presc_d = '0;
                  case (cmd_op)
                     OpClear: begin
                        state_d = StClr;
                     end
                     OpSetRate: begin
                        rate_d  = cmd_arg;
                        state_d = StDone;
                     end
                     OpRunN: begin
                        rem_d   = cmd_arg;
                        dir_d   = 1'b0;
                        state_d = (cmd_arg == 8'd0) ? StDone : StRun;
                     end
                     OpRunTo: begin
                        if (to_dist == 0) begin
                           state_d = StDone;
                        end else if (to_dist <= WIDTH) begin
                           // A tie at half the ring resolves forward
                           dir_d   = 1'b0;
                           rem_d   = 8'(to_dist);
                           state_d = StRun;
                        end else begin
                           dir_d   = 1'b1;
                           rem_d   = 8'(NPH - to_dist);
                           state_d = StRun;
                        end
                     end
                     default: state_d = StIdle;
                  endcase
               end
            end

            StClr: begin
               jc_clr  = 1'b1;
               phase_d = '0;
               state_d = StDone;
            end

            StRun: begin
               if (abort) begin
                  state_d = StDone;
               end else if (presc_q == rate_q) begin
                  jc_step = 1'b1;
                  presc_d = '0;
                  phase_d = dir_q ? phase_rev : phase_fwd;
                  rem_d   = rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
                     state_d = StDone;
                  end
               end else begin
                  presc_d = presc_q + 8'd1;
               end
            end

            StDone: begin
               done    = 1'b1;
               state_d = StIdle;
            end

            default: state_d = StIdle;
         endcase
      end
   end

   // Controller registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         phase_q <= '0;
         rate_q  <= '0;
         presc_q <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rate_q  <= rate_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
      end
   end

   // Expected ring value: fill with ones from the LSB, then drain them from the LSB
   always_comb begin
      pattern = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (int'(phase_q) <= int'(WIDTH)) begin
            pattern[i] = (i < int'(phase_q));
         end else begin
            pattern[i] = (i >= int'(phase_q) - int'(WIDTH));
         end
      end
   end

   assign phase  = phase_q;
   assign jc_dir = dir_q;
   assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Self-checking bench for johnson_step_ctrl: directed scenarios plus random
// command streams, compared against a transaction-level reference model.
module tb_johnson_step_ctrl;

   localparam int W   = 8;
   localparam int NPH = 2 * W;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       abort;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [7:0] cmd_arg;
   logic       cmd_ready;
   logic       jc_step;
   logic       jc_dir;
   logic       jc_clr;
   logic [4:0] phase;
   logic [7:0] pattern;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_phase = 0;
   int m_rate  = 0;

   johnson_step_ctrl #(.WIDTH(8), .PW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .abort     (abort),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .cmd_ready (cmd_ready),
      .jc_step   (jc_step),
      .jc_dir    (jc_dir),
      .jc_clr    (jc_clr),
      .phase     (phase),
      .pattern   (pattern),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Johnson pattern for a phase: p ones from the bottom, or ones in the top 2W-p bits
   function automatic int exp_pattern(input int p);
      if (p <= W) return (1 << p) - 1;
      return (8'hFF << (p - W)) & 8'hFF;
   endfunction

   task automatic check_idle();
      check("idle_busy", busy, 0);
      check("idle_ready", cmd_ready, 1);
      check("idle_phase", phase, m_phase);
      check("idle_pattern", pattern, exp_pattern(m_phase));
   endtask

   // Issue one command and follow it to completion. Called just after a rising
   // edge with the DUT idle; returns just after a rising edge with the DUT idle.
   task automatic run_cmd(input int op, input int arg, input bit ena_rand, input bit abort_rand,
                          input int abort_after, input int hold_at, input int hold_len);
      int  n;
      int  dir;
      int  tgt;
      int  d;
      int  cnt;
      int  issued;
      int  held;
      int  guard;
      bit  fin;
      bit  ena_v;
      bit  abort_v;
      bit  step_exp;
      n   = 0;
      dir = 0;
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_arg   = 8'(arg);
      ena       = 1'b1;
      abort     = 1'b0;
      @(negedge clk);
      check_idle();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_arg   = 8'($urandom);
      cmd_op    = 2'($urandom);

      if (op == 0) begin
         @(negedge clk);
         check("clr_strobe", jc_clr, 1);
         check("clr_busy", busy, 1);
         check("clr_done", done, 0);
         check("clr_step", jc_step, 0);
         m_phase = 0;
         @(posedge clk);
         #1;
      end else if (op == 1) begin
         m_rate = arg;
      end else begin
         if (op == 2) begin
            n   = arg;
            dir = 0;
         end else begin
            tgt = (arg & 31) % NPH;
            d   = (tgt - m_phase + NPH) % NPH;
            if (d == 0) begin
               n = 0;
            end else if (d <= W) begin
               n   = d;
               dir = 0;
            end else begin
               n   = NPH - d;
               dir = 1;
            end
         end
         cnt    = 0;
         issued = 0;
         held   = 0;
         guard  = 0;
         fin    = (n == 0);
         while (!fin) begin
            ena_v = 1'b1;
            if (hold_at >= 0 && cnt >= hold_at && held < hold_len) begin
               ena_v = 1'b0;
               held++;
            end else if (ena_rand) begin
               ena_v = ($urandom_range(7) != 0);
            end
            abort_v = ena_v && ((abort_after >= 0 && issued == abort_after) ||
                                (abort_rand && $urandom_range(19) == 0));
            ena   = ena_v;
            abort = abort_v;
            // A step falls on every (rate+1)-th enabled cycle of the run
            step_exp = ena_v && !abort_v && ((cnt % (m_rate + 1)) == m_rate);
            @(negedge clk);
            check("run_step", jc_step, step_exp);
            check("run_dir", jc_dir, dir);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_clr", jc_clr, 0);
            check("run_ready", cmd_ready, 0);
            check("run_phase", phase, m_phase);
            check("run_pattern", pattern, exp_pattern(m_phase));
            @(posedge clk);
            #1;
            if (ena_v) begin
               if (abort_v) begin
                  fin = 1'b1;
               end else begin
                  if (step_exp) begin
                     m_phase = dir ? (m_phase + NPH - 1) % NPH : (m_phase + 1) % NPH;
                     issued++;
                     if (issued == n) fin = 1'b1;
                  end
                  cnt++;
               end
            end
            guard++;
            if (guard > 4000) begin
               check("run_timeout", guard, 0);
               fin = 1'b1;
            end
         end
         ena   = 1'b1;
         abort = 1'b0;
      end

      // Completion cycle
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_step", jc_step, 0);
      check("done_clr", jc_clr, 0);
      check("done_phase", phase, m_phase);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b1;
      abort     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_arg   = 8'd0;
      #12;
      check("rst_phase", phase, 0);
      check("rst_busy", busy, 0);
      check("rst_step", jc_step, 0);
      check("rst_clr", jc_clr, 0);
      check("rst_done", done, 0);
      check("rst_dir", jc_dir, 0);
      check("rst_pattern", pattern, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ena low blocks acceptance
      ena       = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_arg   = 8'd7;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("ena_lo_ready", cmd_ready, 0);
         check("ena_lo_busy", busy, 0);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      ena       = 1'b1;

      // rate 0, RUN_N 3
      run_cmd(2, 3, 0, 0, -1, -1, 0);
      check("runn3_pattern", pattern, 8'h07);
      check("runn3_phase", phase, 3);

      // CLEAR, SET_RATE 2, RUN_N 2
      run_cmd(0, 0, 0, 0, -1, -1, 0);
      run_cmd(1, 2, 0, 0, -1, -1, 0);
      run_cmd(2, 2, 0, 0, -1, -1, 0);
      check("rate2_phase", phase, 2);

      // RUN_TO reverse then forward tie
      run_cmd(1, 0, 0, 0, -1, -1, 0);
      run_cmd(3, 14, 0, 0, -1, -1, 0);
      check("runto14_pattern", pattern, 8'hC0);
      run_cmd(3, 6, 0, 0, -1, -1, 0);
      check("runto6_phase", phase, 6);

      // Zero-length runs and CLEAR from phase 9; arg bit above PW-1 is ignored
      run_cmd(2, 0, 0, 0, -1, -1, 0);
      run_cmd(3, 8'hE6, 0, 0, -1, -1, 0);
      run_cmd(3, 25, 0, 0, -1, -1, 0);
      check("runto25_phase", phase, 9);
      run_cmd(0, 0, 0, 0, -1, -1, 0);

      // Abort after 4 steps, then ena hold mid-run at rate 3
      run_cmd(2, 10, 0, 0, 4, -1, 0);
      check("abort_phase", phase, 4);
      run_cmd(1, 3, 0, 0, -1, -1, 0);
      run_cmd(2, 4, 0, 0, -1, 5, 5);

      // Random command stream
      for (int k = 0; k < 40; k++) begin
         int op;
         int arg;
         op  = $urandom_range(3);
         arg = $urandom_range(255);
         if (op == 1) arg = $urandom_range(3);
         if (op == 2) arg = $urandom_range(20);
         run_cmd(op, arg, 1, 1, -1, -1, 0);
      end

      // Reset in the middle of RUN_N 10 from phase 4 with a nonzero rate
      run_cmd(0, 0, 0, 0, -1, -1, 0);
      run_cmd(2, 4, 0, 0, -1, -1, 0);
      run_cmd(1, 1, 0, 0, -1, -1, 0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_arg   = 8'd10;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_phase", phase, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_step", jc_step, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_clr", jc_clr, 0);
      check("mid_rst_dir", jc_dir, 0);
      check("mid_rst_pattern", pattern, 0);
      m_phase = 0;
      m_rate  = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      // Rate must be back to 0: steps on consecutive cycles
      run_cmd(2, 3, 0, 0, -1, -1, 0);
      check("post_rst_phase", phase, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/johnson_step_ctrl.md
Name: johnson_step_ctrl

Overview:
Command-driven sequencer for the 8-bit Johnson ring counter datapath. It accepts simple commands (clear, set step rate, run N steps, run to a target phase), issues one-cycle step/clear strobes with a direction, and tracks the ring's current phase. A decoded copy of the expected ring pattern is provided so the ring can be cross-checked against the controller. It sits between the pin-level command decode and the ring register.

Parameters:
WIDTH, 8, Johnson ring width; the ring has 2*WIDTH phases.
PW, 5, phase index width; must satisfy 2^PW >= 2*WIDTH.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes the controller
abort  input  1  terminates an active run
cmd_valid  input  1  command present
cmd_op  input  2  00 CLEAR, 01 SET_RATE, 10 RUN_N, 11 RUN_TO
cmd_arg  input  8  command argument
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
jc_step  output  1  one-cycle step strobe to the ring
jc_dir  output  1  0 = forward (shift left, ~MSB into LSB); 1 = reverse (shift right, ~LSB into MSB)
jc_clr  output  1  one-cycle clear strobe to the ring
phase  output  PW  current ring phase, 0..2*WIDTH-1
pattern  output  WIDTH  expected ring value for the current phase
busy  output  1  high when the controller is not in IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n low) clears: state=IDLE, phase=0, rate=0, prescaler=0, remaining=0, jc_dir=0. All strobes, busy and done are 0.
- States: IDLE, CLR, RUN, DONE.
- cmd_ready = ena & (state==IDLE). A command arriving with cmd_valid high outside IDLE is not accepted; the source holds it.
- Commands, with acceptance at edge T:
  - CLEAR: go to CLR; jc_clr=1 for one cycle; phase<=0; then DONE.
  - SET_RATE: rate<=cmd_arg; go to DONE (the done pulse appears at T+1).
  - RUN_N: remaining<=cmd_arg; jc_dir<=0. If cmd_arg==0, go to DONE; otherwise go to RUN.
  - RUN_TO: target = cmd_arg[PW-1:0] mod 2*WIDTH, and d = (target - phase) mod 2*WIDTH.
    - d==0: go to DONE with no steps.
    - d<=WIDTH: jc_dir=0, remaining=d.
    - Otherwise: jc_dir=1, remaining=2*WIDTH-d.
    - A tie (d==WIDTH) runs forward.
- RUN:
  - The prescaler is 0 on entry. jc_step=1 in the cycle where prescaler==rate and ena=1. The prescaler then returns to 0; otherwise it increments.
  - The first step occurs rate+1 cycles after acceptance. Steps repeat every rate+1 cycles.
  - On each step edge: phase <= phase+1 mod 2*WIDTH (forward) or phase-1 mod 2*WIDTH (reverse), and remaining decrements.
  - A step issued with remaining==1 moves the state to DONE.
  - jc_dir is stable for the whole run.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in CLR, RUN and DONE.
- abort: if abort=1 in RUN, jc_step is suppressed that cycle and the state goes to DONE. Phase reflects only the steps actually issued. abort is ignored outside RUN.
- ena=0: state, prescaler and phase freeze. No jc_step and no jc_clr are issued (a CLR in progress stalls). cmd_ready=0.
- pattern (combinational from phase p):
  - p<=WIDTH: low p bits are 1, the rest 0.
  - p>WIDTH: top (2*WIDTH-p) bits are 1, the rest 0.
  - Example with WIDTH=8: p=3 gives 0x07, p=8 gives 0xFF, p=12 gives 0xF0.
- Phase wrap: 15 forward gives 0; 0 reverse gives 15.

Test Plan:
- Reset mid-RUN (rst_n low with a RUN_N 10 in progress at phase 4) -> all outputs 0 immediately, phase=0, rate=0; cmd_ready=1 one cycle after release with ena=1.
- rate=0, RUN_N 3 from phase 0 -> jc_step high on 3 consecutive cycles starting at T+1, jc_dir=0, phase 1,2,3, pattern=0x07; done pulse one cycle after the last step.
- SET_RATE 2, then RUN_N 2 -> steps at T+3 and T+6 only; phase goes 0->2; done at T+7.
- From phase 2, RUN_TO 14 -> d=12, so jc_dir=1 with 4 steps, phase 1,0,15,14, pattern=0xC0. RUN_TO 6 from phase 14 -> d=8 (tie), forward 8 steps wrapping through 0 to phase 6.
- RUN_N 0 and RUN_TO the current phase -> no jc_step, done at T+1, busy high for one cycle. CLEAR at phase 9 -> jc_clr at T+1, phase=0, done at T+2.
- abort during RUN_N 10 after 4 steps -> no further jc_step, phase=4, done the next cycle. ena held low for 5 cycles mid-run -> no steps during the hold, and the step schedule resumes from the frozen prescaler value.
